// File: rtl/aes_io_pkg.sv
// Shared definitions for the AES I/O paths: block geometry, UART defaults and
// the receiver state encoding.
package aes_io_pkg;
  localparam int AES_BLOCK_BITS   = 128;
  localparam int AES_BLOCK_BYTES  = 16;
  localparam int CLK_FREQ_DEFAULT = 100_000_000;
  localparam int BAUD_DEFAULT     = 115_200;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle
// byte_done / stop_err pulses. byte_data is valid while byte_done is high.
module uart_rx_byte
  import aes_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic       byte_done,
  output logic [7:0] byte_data,
  output logic       stop_err,
  output logic       rx_idle
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

  rx_state_t     r_state;
  logic          r_sync1, r_sync2;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_done, r_err;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_state  <= RX_IDLE;
      r_timer  <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      unique case (r_state)
        RX_IDLE: begin
          if (!r_sync2) begin
            r_state <= RX_START;
            r_timer <= '0;
          end
        end
        RX_START: begin
          // Mid-start-bit recheck; a line already high again was a glitch
          if (r_timer == T_HALF) begin
            r_timer  <= '0;
            r_bitcnt <= '0;
            r_state  <= r_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_timer == T_FULL) begin
            r_timer <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            if (r_bitcnt == 3'd7) r_state <= RX_STOP;
            else                  r_bitcnt <= r_bitcnt + 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_timer == T_FULL) begin
            r_timer <= '0;
            if (r_sync2) begin
              r_done  <= 1'b1;
              r_state <= RX_IDLE;
            end else begin
              r_err   <= 1'b1;
              r_state <= RX_BREAK;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RX_BREAK: begin
          if (r_sync2) r_state <= RX_IDLE;
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign byte_done = r_done;
  assign byte_data = r_shift;
  assign stop_err  = r_err;
  assign rx_idle   = (r_state == RX_IDLE);
endmodule

// File: rtl/aes_uart_block_loader.sv
// Collects 16 UART bytes into a 128-bit AES operand block (first byte in the
// top byte) and offers it downstream on a valid/ready handshake.
module aes_uart_block_loader
  import aes_io_pkg::*;
#(
  parameter int CLK_FREQ     = CLK_FREQ_DEFAULT,
  parameter int BAUD         = BAUD_DEFAULT,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      uart_rx,
  input  logic                      clear,
  input  logic                      block_ready,
  output logic [AES_BLOCK_BITS-1:0] block_data,
  output logic                      block_valid,
  output logic [4:0]                byte_count,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      timeout
);
  localparam int TOW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [4:0]     FULL_CNT = 5'(AES_BLOCK_BYTES);
  localparam logic [TOW-1:0] TO_LIMIT = TOW'(TIMEOUT_CLKS);

  logic                      w_byte_done, w_stop_err, w_rx_idle;
  logic [7:0]                w_byte_data;
  logic                      w_xfer, w_store, w_to_run, w_to_fire;
  logic [4:0]                w_idx;
  logic [AES_BLOCK_BITS-1:0] r_data;
  logic [4:0]                r_count;
  logic                      r_valid, r_ferr, r_ovr, r_tmo;
  logic [TOW-1:0]            r_idle_cnt;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (uart_rx),
    .byte_done (w_byte_done),
    .byte_data (w_byte_data),
    .stop_err  (w_stop_err),
    .rx_idle   (w_rx_idle)
  );

  // A byte landing on the transfer cycle becomes byte 0 of the next block
  always_comb begin
    w_xfer    = r_valid && block_ready;
    w_store   = w_byte_done && (!r_valid || w_xfer);
    w_idx     = w_xfer ? '0 : r_count;
    w_to_run  = w_rx_idle && (r_count != '0) && (r_count < FULL_CNT);
    w_to_fire = w_to_run && (r_idle_cnt == TO_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data     <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovr      <= 1'b0;
      r_tmo      <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= (w_to_run && !w_to_fire) ? r_idle_cnt + 1'b1 : '0;
      if (clear) begin
        r_count <= '0;
        r_valid <= 1'b0;
        r_ferr  <= 1'b0;
        r_ovr   <= 1'b0;
        r_tmo   <= 1'b0;
      end else begin
        if (w_stop_err) r_ferr <= 1'b1;
        if (w_byte_done && r_valid && !w_xfer) r_ovr <= 1'b1;
        if (w_store) begin
          for (int unsigned i = 0; i < AES_BLOCK_BYTES; i++) begin
            if (w_idx == 5'(i)) r_data[AES_BLOCK_BITS-1-8*i -: 8] <= w_byte_data;
          end
          r_count <= w_idx + 5'd1;
          r_valid <= (w_idx + 5'd1) == FULL_CNT;
        end else if (w_xfer) begin
          r_count <= '0;
          r_valid <= 1'b0;
        end else if (w_to_fire) begin
          r_count <= '0;
          r_tmo   <= 1'b1;
        end
      end
    end
  end

  assign block_data  = r_data;
  assign block_valid = r_valid;
  assign byte_count  = r_count;
  assign frame_err   = r_ferr;
  assign overrun     = r_ovr;
  assign timeout     = r_tmo;
endmodule

// File: tb/tb_aes_uart_block_loader.sv
// Directed bench for aes_uart_block_loader with a transaction-level model of
// the block assembler checked on every quiet cycle.
module tb_aes_uart_block_loader;
  localparam int CPB = 10;

  logic         clk = 1'b0;
  logic         reset_n, uart_rx, clear, block_ready;
  logic [127:0] block_data;
  logic         block_valid, frame_err, overrun, timeout;
  logic [4:0]   byte_count;

  aes_uart_block_loader #(
    .CLK_FREQ     (1_000_000),
    .BAUD         (100_000),
    .TIMEOUT_CLKS (200)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .uart_rx     (uart_rx),
    .clear       (clear),
    .block_ready (block_ready),
    .block_data  (block_data),
    .block_valid (block_valid),
    .byte_count  (byte_count),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int   n_pass = 0, n_total = 0;
  logic busy = 1'b1;

  // Model state: what the outputs must be once the line is quiet
  logic [7:0] m_bytes [16];
  int         m_count = 0;
  logic       m_valid = 0, m_ferr = 0, m_ovr = 0, m_tmo = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_valid) m_ovr = 1;
    else begin
      m_bytes[m_count] = b;
      m_count++;
      if (m_count == 16) m_valid = 1;
    end
  endtask

  task automatic model_clear();
    m_count = 0; m_valid = 0; m_ferr = 0; m_ovr = 0; m_tmo = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cyc(CPB);
    end
    uart_rx = stop_bit;
    wait_cyc(CPB);
    uart_rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    busy = 1;
    send_frame(b, 1'b1);
    model_byte(b);
    busy = 0;
    wait_cyc(2);
  endtask

  task automatic pulse_ready(input logic with_clear);
    busy = 1;
    block_ready = 1'b1;
    clear = with_clear;
    wait_cyc(1);
    block_ready = 1'b0;
    clear = 1'b0;
    if (with_clear) model_clear();
    else if (m_valid) begin m_valid = 0; m_count = 0; end
    busy = 0;
  endtask

  // Continuous comparison against the model plus the valid-rise property
  logic       prev_valid = 0;
  logic [4:0] prev_cnt = '0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (block_valid && !prev_valid)
        chk("valid_rise_with_count", {118'd0, prev_cnt, byte_count}, {118'd0, 5'd15, 5'd16});
      if (!busy) begin
        chk("byte_count", 128'(byte_count), 128'(m_count));
        chk("block_valid", 128'(block_valid), 128'(m_valid));
        chk("frame_err", 128'(frame_err), 128'(m_ferr));
        chk("overrun", 128'(overrun), 128'(m_ovr));
        chk("timeout", 128'(timeout), 128'(m_tmo));
        for (int i = 0; i < m_count; i++)
          chk("block_byte", 128'(block_data[127-8*i -: 8]), 128'(m_bytes[i]));
      end
      prev_valid = block_valid;
      prev_cnt   = byte_count;
    end else begin
      prev_valid = 1'b0;
      prev_cnt   = '0;
    end
  end

  task automatic chk_all_zero(input string name);
    chk(name, {block_data, byte_count, block_valid, frame_err, overrun, timeout}, '0);
  endtask

  initial begin
    reset_n = 1'b0; uart_rx = 1'b1; clear = 1'b0; block_ready = 1'b0;
    wait_cyc(3);
    chk_all_zero("reset_outputs");
    reset_n = 1'b1;
    busy = 0;
    wait_cyc(2);

    // Full block 00,11,..,FF
    for (int i = 0; i < 16; i++) send_good(8'(i * 8'h11));
    chk("block1_data", block_data, 128'h00112233445566778899aabbccddeeff);
    chk("block1_count", 128'(byte_count), 128'd16);
    chk("block1_valid", 128'(block_valid), 128'd1);

    // Overrun while held, then handshake
    send_good(8'h5A);
    chk("overrun_set", 128'(overrun), 128'd1);
    chk("overrun_data_held", block_data, 128'h00112233445566778899aabbccddeeff);
    pulse_ready(1'b0);
    chk("handshake_clears", {126'd0, block_valid, |byte_count}, '0);
    wait_cyc(2);

    // Framing error, long break, then a clean byte
    busy = 1;
    send_frame(8'h3C, 1'b0);
    uart_rx = 1'b0;
    wait_cyc(50);
    uart_rx = 1'b1;
    m_ferr = 1;
    busy = 0;
    wait_cyc(10);
    chk("frame_err_set", {frame_err, byte_count}, {1'b1, 5'd0});
    send_good(8'h3C);
    chk("after_break_byte0", {block_data[127:120], byte_count}, {8'h3C, 5'd1});

    // Short glitch: nothing changes
    busy = 1;
    uart_rx = 1'b0;
    wait_cyc(4);
    uart_rx = 1'b1;
    wait_cyc(30);
    busy = 0;
    wait_cyc(2);
    chk("glitch_no_byte", 128'(byte_count), 128'd1);

    // Clear, five bytes, idle into timeout, clear again
    busy = 1; clear = 1'b1; wait_cyc(1); clear = 1'b0; model_clear(); busy = 0;
    wait_cyc(2);
    chk("clear_flags", {frame_err, overrun, timeout}, '0);
    for (int i = 0; i < 5; i++) send_good(8'hA0 + 8'(i));
    busy = 1;
    wait_cyc(250);
    m_count = 0; m_tmo = 1;
    busy = 0;
    wait_cyc(2);
    chk("timeout_fired", {timeout, byte_count}, {1'b1, 5'd0});
    busy = 1; clear = 1'b1; wait_cyc(1); clear = 1'b0; model_clear(); busy = 0;
    wait_cyc(2);
    chk("clear_after_timeout", {frame_err, overrun, timeout, byte_count}, '0);

    // Reset in the middle of byte 9
    for (int i = 0; i < 8; i++) send_good(8'h40 + 8'(i));
    busy = 1;
    uart_rx = 1'b0;
    wait_cyc(40);
    uart_rx = 1'b1;
    reset_n = 1'b0;
    wait_cyc(1);
    chk_all_zero("midbyte_reset");
    reset_n = 1'b1;
    model_clear();
    wait_cyc(12);
    busy = 0;
    for (int i = 0; i < 16; i++) send_good(8'(8'hFF - 8'(i * 8'h11)));
    chk("block2_data", block_data, 128'hffeeddccbbaa99887766554433221100);

    // Overrun then clear together with ready: clear wins
    send_good(8'h77);
    chk("overrun2_set", 128'(overrun), 128'd1);
    pulse_ready(1'b1);
    chk("clear_over_xfer", {block_valid, overrun, byte_count}, '0);
    wait_cyc(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/aes_uart_block_loader.md
Name: aes_uart_block_loader

Overview:
- Input-side counterpart to the AES display path.
- Receives 16 bytes over a UART RX line (8N1, LSB first) and assembles them into one 128-bit block.
- Presents the block to the AES launch logic through a valid/ready handshake; the display path consumes AES results, this block sources AES operands.
- Provides byte-progress and error status for the 7-segment/LED status path.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD, clocks per UART bit (868 at defaults); must be at least 4.
- TIMEOUT_CLKS, 20*CLKS_PER_BIT, idle time after which a partial block is discarded.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- uart_rx  in  1  asynchronous serial input; idles high.
- clear  in  1  synchronous discard of any partial or held block; also clears the sticky flags.
- block_ready  in  1  downstream accepts the block.
- block_data  out  128  assembled block; first received byte sits in [127:120].
- block_valid  out  1  block_data is complete and stable.
- byte_count  out  5  bytes collected in the current block, 0..16.
- frame_err  out  1  sticky; a stop bit was sampled low.
- overrun  out  1  sticky; a byte arrived while block_valid was held.
- timeout  out  1  sticky; a partial block was discarded by the idle timeout.

Behaviour:
- Reset (reset_n low at a clk edge) clears all outputs, the receiver FSM (to IDLE), all counters and the synchronizer flops (to 1). It aborts any byte or block in flight.
- uart_rx passes through a 2-flop synchronizer before use; this adds 2 cycles of latency.
- Receiver FSM:
  - IDLE: a low synced rx enters START and resets the bit timer.
  - START: at CLKS_PER_BIT/2 the line is resampled. Low enters DATA; high is a glitch, returns to IDLE with no flag.
  - DATA: samples every CLKS_PER_BIT, 8 bits, LSB first, then enters STOP.
  - STOP: samples after CLKS_PER_BIT. High produces a byte_done pulse for 1 cycle and returns to IDLE. Low sets frame_err, discards the byte, and enters BREAK.
  - BREAK: waits for synced rx high, then returns to IDLE.
- Assembler:
  - On byte_done with block_valid low, the byte is written to bits [127-8*n -: 8], where n = byte_count, and byte_count increments.
  - When byte_count reaches 16, block_valid rises in the same cycle as the count update, i.e. one cycle after the 16th byte_done.
  - While block_valid is high, block_data and byte_count hold. A byte_done arriving in this state is dropped and sets overrun.
  - Handshake: a transfer occurs on the cycle where block_valid and block_ready are both high. On the next cycle block_valid=0 and byte_count=0.
  - byte_done in the same cycle as a transfer is accepted as byte 0 of the new block; byte_count becomes 1 next cycle.
- Timeout:
  - The idle counter runs only while 0 < byte_count < 16 and the FSM is in IDLE; it resets on any start-bit detection.
  - When the counter hits TIMEOUT_CLKS, byte_count goes to 0 and timeout is set. block_data content is don't-care.
- clear:
  - Forces byte_count=0, block_valid=0, and clears all three sticky flags.
  - Does not reset the receiver FSM, so a byte in flight still completes and is stored as byte 0.
  - clear has priority over a simultaneous handshake or byte_done store.
- Widths: the bit timer is clog2(CLKS_PER_BIT) bits and the timeout counter is clog2(TIMEOUT_CLKS+1) bits. There is no wrap-around; both saturate or reset as defined above.

Decomposition:
- Shared package aes_io_pkg holds:
  - AES_BLOCK_BITS=128 and AES_BLOCK_BYTES=16;
  - the receiver state encoding (IDLE, START, DATA, STOP, BREAK);
  - the default CLK_FREQ and BAUD.
- One sub-module, uart_rx_byte: synchronizer plus receiver FSM, outputting byte_done, byte_data[7:0] and stop_err.
- The top level holds the assembler, the handshake, the timeout and the sticky flags.

Test Plan:
- Bench parameters: CLK_FREQ=1_000_000, BAUD=100_000 (CLKS_PER_BIT=10), TIMEOUT_CLKS=200.
- Send bytes 00,11,...,FF with block_ready=0 -> block_valid=1 one cycle after the 16th byte_done; block_data=128'h00112233445566778899aabbccddeeff; byte_count=16.
- Hold block_ready=0 and send byte 0x5A -> overrun=1, block_data unchanged. Then pulse block_ready for 1 cycle -> next cycle block_valid=0, byte_count=0.
- Send byte 0x3C with the stop bit low -> frame_err=1, byte_count unchanged. Hold rx low for 50 cycles, then send 0x3C correctly -> byte_count +1, [127:120]=0x3C.
- 4-cycle low pulse on idle rx -> no byte_done, no flags set, FSM back in IDLE.
- Send 5 bytes, then idle 200 cycles -> timeout=1, byte_count=0. Assert clear -> all flags 0.
- Assert reset_n=0 for 1 cycle mid-byte at byte 9 -> all outputs 0. The subsequent 16 bytes assemble correctly from [127:120].
